// File: rtl/instruc_assembler.sv
// Packs UART bytes (MSB first) into 32-bit instruction words and queues them in a
// first-word-fall-through FIFO; assembling HALT_WORD closes the download.
module instruc_assembler #(
  parameter int          DEPTH     = 64,
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  input  logic              clear,
  input  logic              rd,
  output logic [31:0]       dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        byte_idx,
  output logic              overflow,
  output logic              prog_done
);

  typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t            state_r, state_s;
  logic [23:0]       asm_r;
  logic [1:0]        byte_idx_r;
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              overflow_r, prog_done_r;
  logic [31:0]       mem_r [DEPTH];

  logic              empty_s, full_s, tick_s, complete_s, push_s, pop_s, drop_s, halt_s;
  logic [31:0]       word_s;

  assign empty_s   = (count_r == {(ADDR_W + 1){1'b0}});
  assign full_s    = (count_r == DEPTH_C);
  assign word_s    = {asm_r, rx_data};

  assign dout      = mem_r[rd_ptr_r];
  assign empty     = empty_s;
  assign full      = full_s;
  assign count     = count_r;
  assign byte_idx  = byte_idx_r;
  assign overflow  = overflow_r;
  assign prog_done = prog_done_r;

  // Accepted-byte, push/pop/drop decisions and next FSM state; clear masks everything.
  always_comb begin
    tick_s     = 1'b0;
    complete_s = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    drop_s     = 1'b0;
    halt_s     = 1'b0;
    state_s    = state_r;
    if (!clear) begin
      tick_s     = rx_done_tick && (state_r == COLLECT);
      complete_s = tick_s && (byte_idx_r == 2'd3);
      // A full FIFO always has a head to pop, so rd alone frees the slot.
      push_s     = complete_s && (!full_s || rd);
      drop_s     = complete_s && full_s && !rd;
      pop_s      = rd && !empty_s;
      halt_s     = complete_s && (word_s == HALT_WORD);
    end else begin
      tick_s     = 1'b0;
    end
    case (state_r)
      COLLECT: begin
        if (halt_s) begin
          state_s = DONE;
        end else begin
          state_s = COLLECT;
        end
      end
      DONE:    state_s = DONE;
      default: state_s = COLLECT;
    endcase
  end

  // Control registers: assembly, pointers, occupancy, sticky flags and FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= COLLECT;
      asm_r       <= 24'h00_0000;
      byte_idx_r  <= 2'd0;
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count_r     <= {(ADDR_W + 1){1'b0}};
      overflow_r  <= 1'b0;
      prog_done_r <= 1'b0;
    end else if (clear) begin
      state_r     <= COLLECT;
      asm_r       <= 24'h00_0000;
      byte_idx_r  <= 2'd0;
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count_r     <= {(ADDR_W + 1){1'b0}};
      overflow_r  <= 1'b0;
      prog_done_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (tick_s) begin
        if (byte_idx_r == 2'd3) begin
          byte_idx_r <= 2'd0;
          asm_r      <= 24'h00_0000;
        end else begin
          byte_idx_r <= byte_idx_r + 2'd1;
          asm_r      <= word_s[23:0];
        end
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (ADDR_W + 1)'(1);
        2'b01:   count_r <= count_r - (ADDR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (halt_s) begin
        prog_done_r <= 1'b1;
      end
    end
  end

  // Word storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

endmodule

// File: tb/tb_instruc_assembler.sv
// Directed bench for instruc_assembler: a queue-based model is compared every cycle,
// and literal expectations at key points pin the model.
module tb_instruc_assembler;
  localparam int          DEPTH  = 64;
  localparam int          ADDR_W = 6;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_done_tick = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              clear = 1'b0;
  logic              rd = 1'b0;
  logic [31:0]       dout;
  logic              empty, full;
  logic [ADDR_W:0]   count;
  logic [1:0]        byte_idx;
  logic              overflow, prog_done;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  instruc_assembler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .clear(clear), .rd(rd), .dout(dout), .empty(empty), .full(full),
    .count(count), .byte_idx(byte_idx), .overflow(overflow), .prog_done(prog_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the FIFO is a queue, the partial word a shifting 32-bit value.
  logic [31:0] q[$];
  logic [31:0] part;
  int          bidx;
  bit          m_ovf, m_pdone, m_done;

  always @(posedge clk or posedge reset) begin
    bit was_full;
    if (reset || clear) begin
      q.delete(); part = 32'h0; bidx = 0; m_ovf = 1'b0; m_pdone = 1'b0; m_done = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      if (rd && q.size() != 0) void'(q.pop_front());
      if (!m_done && rx_done_tick) begin
        part = {part[23:0], rx_data};
        bidx++;
        if (bidx == 4) begin
          bidx = 0;
          if (!was_full || rd) q.push_back(part);
          else m_ovf = 1'b1;
          if (part == HALT) begin
            m_pdone = 1'b1;
            m_done  = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started && !reset) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("byte_idx", 32'(byte_idx), 32'(bidx));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("prog_done", 32'(prog_done), 32'(m_pdone));
      if (q.size() != 0) chk("dout", dout, q[0]);
    end
  end

  function automatic logic [31:0] wd(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done_tick = 1'b1; rx_data = b;
    tick();
    rx_done_tick = 1'b0;
  endtask

  // Four back-to-back bytes; rd_last pops at the completing edge.
  task automatic send_word(input logic [31:0] w, input bit rd_last);
    for (int i = 3; i >= 0; i--) begin
      rx_done_tick = 1'b1; rx_data = w[8*i +: 8];
      rd = (i == 0) && rd_last;
      tick();
    end
    rx_done_tick = 1'b0; rd = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] bytes4;
    idle(3);
    reset = 1'b0;
    started = 1'b1;
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_byte_idx", 32'(byte_idx), 32'd0);
    chk("rst_flags", {30'd0, overflow, prog_done}, 32'd0);

    // Single word with idle gaps between bytes.
    bytes4 = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes4[8*(3-i) +: 8]);
      chk("t1_byte_idx", 32'(byte_idx), 32'((i + 1) % 4));
      if (i < 3) idle(3);
    end
    chk("t1_empty", 32'(empty), 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_dout", dout, 32'h1234_5678);
    pop();
    chk("t1_empty_after", 32'(empty), 32'd1);
    chk("t1_count_after", 32'(count), 32'd0);

    // DEPTH+1 words without reads: last one overflows; drain in order.
    do_clear();
    for (int i = 1; i <= DEPTH; i++) send_word(wd(i), 1'b0);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count", 32'(count), 32'(DEPTH));
    chk("t2_ovf_before", 32'(overflow), 32'd0);
    send_word(wd(DEPTH + 1), 1'b0);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_count_hold", 32'(count), 32'(DEPTH));
    for (int i = 1; i <= DEPTH; i++) begin
      chk("t2_drain", dout, wd(i));
      pop();
    end
    chk("t2_empty", 32'(empty), 32'd1);

    // Full FIFO: completing byte with a simultaneous pop is accepted.
    do_clear();
    for (int i = 1; i <= DEPTH; i++) send_word(wd(i), 1'b0);
    x = 32'hCAFE_0042;
    for (int i = 3; i >= 1; i--) send_byte(x[8*i +: 8]);
    chk("t3_head", dout, wd(1));
    rx_done_tick = 1'b1; rx_data = x[7:0]; rd = 1'b1;
    tick();
    rx_done_tick = 1'b0; rd = 1'b0;
    chk("t3_count", 32'(count), 32'(DEPTH));
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("t3_last", dout, x);
      else chk("t3_drain", dout, wd(i + 2));
      pop();
    end

    // Halt word closes the download; trailing bytes ignored; clear reopens.
    do_clear();
    send_word(32'hDEAD_BEEF, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    chk("t4_pdone", 32'(prog_done), 32'd1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    chk("t4_count", 32'(count), 32'd2);
    chk("t4_byte_idx", 32'(byte_idx), 32'd0);
    chk("t4_dout", dout, 32'hDEAD_BEEF);
    do_clear();
    chk("t4_pdone_clr", 32'(prog_done), 32'd0);
    chk("t4_empty_clr", 32'(empty), 32'd1);
    send_word(32'h1122_3344, 1'b0);
    chk("t4_collect", 32'(count), 32'd1);

    // Clear, then reset, coinciding with a third byte: no stale bytes survive.
    do_clear();
    send_byte(8'h55); send_byte(8'h66);
    rx_done_tick = 1'b1; rx_data = 8'h99; clear = 1'b1;
    tick();
    rx_done_tick = 1'b0; clear = 1'b0;
    chk("t5_clr_byte_idx", 32'(byte_idx), 32'd0);
    send_word(32'hA0A1_A2A3, 1'b0);
    chk("t5_clr_dout", dout, 32'hA0A1_A2A3);
    send_byte(8'h55); send_byte(8'h66);
    rx_done_tick = 1'b1; rx_data = 8'h99; reset = 1'b1;
    tick();
    rx_done_tick = 1'b0; reset = 1'b0;
    tick();
    chk("t5_rst_byte_idx", 32'(byte_idx), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    send_word(32'hA0A1_A2A3, 1'b0);
    chk("t5_rst_dout", dout, 32'hA0A1_A2A3);

    // Push and pop on the same edge across the pointer wrap.
    do_clear();
    send_word(wd(500), 1'b0);
    send_word(wd(501), 1'b0);
    for (int k = 0; k < DEPTH + 5; k++) begin
      for (int i = 3; i >= 1; i--) send_byte(wd(600 + k) >> (8 * i));
      chk("t6_head", dout, (k < 2) ? wd(500 + k) : wd(600 + k - 2));
      rx_done_tick = 1'b1; rx_data = wd(600 + k) & 32'h0000_00FF; rd = 1'b1;
      tick();
      rx_done_tick = 1'b0; rd = 1'b0;
      chk("t6_count", 32'(count), 32'd2);
    end
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_tail0", dout, wd(600 + DEPTH + 3));
    pop();
    chk("t6_tail1", dout, wd(600 + DEPTH + 4));
    pop();
    chk("t6_empty", 32'(empty), 32'd1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
